// File: rtl/pw_defs.sv
// Definitions shared across the password-detection button path: FSM encoding,
// button bit positions and default timing derived from the debounce settle time.
package pw_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_B = 1;
  localparam int unsigned BTN_C = 2;
  localparam int unsigned BTN_D = 3;

  // Press and gap both comfortably exceed the debounce filter's settle window.
  localparam int unsigned DEBOUNCE_SETTLE_CYCLES = 250;
  localparam int unsigned DEFAULT_PRESS_CYCLES   = 4 * DEBOUNCE_SETTLE_CYCLES;
  localparam int unsigned DEFAULT_GAP_CYCLES     = 2 * DEBOUNCE_SETTLE_CYCLES;

  function automatic int unsigned counter_width(input int unsigned press, input int unsigned gap);
    int unsigned longest;
    int unsigned w;
    longest = (press > gap) ? press : gap;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_sequence_player_phase_timer.sv
// Loadable down counter timing the PRESS and GAP phases; holds at zero.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clkin) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/button_sequence_player.sv
// Replays a latched sequence of button masks (chords allowed) onto four
// registered button lines, each press followed by an all-low gap.
module button_sequence_player
  import pw_defs::*;
#(
  parameter int unsigned PRESS_CYCLES = DEFAULT_PRESS_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES,
  parameter int unsigned MAX_STEPS    = 8
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*MAX_STEPS-1:0] seq_data,
  input  logic [3:0]             seq_len,
  output logic                   a_out,
  output logic                   b_out,
  output logic                   c_out,
  output logic                   d_out,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             step_idx
);

  localparam int unsigned    CW         = counter_width(PRESS_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]  PRESS_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]     MAX_LEN    = 4'(MAX_STEPS);

  state_t                 state;
  logic [4*MAX_STEPS-1:0] seq_reg;
  logic [3:0]             len_reg;
  logic [3:0]             buttons;

  logic                   timer_load;
  logic [CW-1:0]          timer_value;
  logic                   expired;
  logic [3:0]             next_idx;
  logic [3:0]             next_mask;
  logic                   last_step;
  logic                   accept;

  phase_timer #(.WIDTH(CW)) u_timer (
    .clkin   (clkin),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (expired)
  );

  always_comb begin
    accept    = start && (seq_len != '0);
    next_idx  = step_idx + 4'd1;
    next_mask = seq_reg[4*next_idx +: 4];
    last_step = (step_idx == len_reg - 4'd1);
  end

  // Timer reloads exactly on the edge a phase begins, so phases abut with no dead cycles.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      IDLE: if (accept) begin
        timer_load  = 1'b1;
        timer_value = PRESS_LOAD;
      end
      PRESS: if (expired) begin
        timer_load  = 1'b1;
        timer_value = GAP_LOAD;
      end
      GAP: if (expired && !last_step) begin
        timer_load  = 1'b1;
        timer_value = PRESS_LOAD;
      end
      DONE: ;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state    <= IDLE;
      seq_reg  <= '0;
      len_reg  <= '0;
      buttons  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= PRESS;
            seq_reg  <= seq_data;
            len_reg  <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
            step_idx <= '0;
            buttons  <= seq_data[3:0];
            busy     <= 1'b1;
          end
        end
        PRESS: begin
          if (abort) begin
            state    <= IDLE;
            buttons  <= '0;
            busy     <= 1'b0;
            step_idx <= '0;
          end else if (expired) begin
            state   <= GAP;
            buttons <= '0;
          end
        end
        GAP: begin
          if (abort) begin
            state    <= IDLE;
            buttons  <= '0;
            busy     <= 1'b0;
            step_idx <= '0;
          end else if (expired) begin
            if (last_step) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              step_idx <= '0;
            end else begin
              state    <= PRESS;
              step_idx <= next_idx;
              buttons  <= next_mask;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign a_out = buttons[BTN_A];
  assign b_out = buttons[BTN_B];
  assign c_out = buttons[BTN_C];
  assign d_out = buttons[BTN_D];

endmodule

// File: tb/tb_button_sequence_player.sv
// Bench for button_sequence_player: directed scenarios plus random traffic,
// compared every cycle against a timeline model of the playback.
module tb_button_sequence_player;

  localparam int P = 4;
  localparam int G = 2;
  localparam int M = 8;

  logic           clkin = 1'b0;
  logic           reset, start, abort;
  logic [4*M-1:0] seq_data;
  logic [3:0]     seq_len;
  logic           a_out, b_out, c_out, d_out, busy, done;
  logic [3:0]     step_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy   = 0;
  int n_done   = 0;

  always #5 clkin = ~clkin;

  button_sequence_player #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G),
    .MAX_STEPS    (M)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .seq_data (seq_data),
    .seq_len  (seq_len),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_out    (c_out),
    .d_out    (d_out),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  // Model: m_t is the cycle offset since the accepted start (-1 when idle);
  // offset len*(P+G) is the done cycle.
  int         m_t   = -1;
  int         m_len = 0;
  logic [3:0] m_mask [M];

  always @(posedge clkin) begin
    if (reset) begin
      m_t   <= -1;
      m_len <= 0;
    end else if (m_t < 0) begin
      if (start && seq_len != 0) begin
        m_len <= (int'(seq_len) > M) ? M : int'(seq_len);
        for (int i = 0; i < M; i++) m_mask[i] <= seq_data[4*i +: 4];
        m_t <= 0;
      end
    end else if (m_t < m_len * (P + G)) begin
      m_t <= abort ? -1 : m_t + 1;
    end else begin
      m_t <= -1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0] e_btn;
    logic       e_busy, e_done;
    int         e_idx;
    e_btn = '0; e_busy = 1'b0; e_done = 1'b0; e_idx = 0;
    if (m_t >= 0) begin
      if (m_t < m_len * (P + G)) begin
        e_idx  = m_t / (P + G);
        e_busy = 1'b1;
        if (m_t % (P + G) < P) e_btn = m_mask[e_idx];
      end else begin
        e_done = 1'b1;
      end
    end
    check("buttons", {28'd0, d_out, c_out, b_out, a_out}, {28'd0, e_btn});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("done", {31'd0, done}, {31'd0, e_done});
    check("step_idx", {28'd0, step_idx}, 32'(e_idx));
  endtask

  task automatic tick();
    @(posedge clkin);
    @(negedge clkin);
    compare();
    if (busy === 1'b1) n_busy++;
    if (done === 1'b1) n_done++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic play(input logic [31:0] data, input logic [3:0] len);
    seq_data = data;
    seq_len  = len;
    start    = 1'b1;
    n_busy   = 0;
    n_done   = 0;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0; seq_data = '0;
    run(2);
    check("reset_lines", {28'd0, d_out, c_out, b_out, a_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_idx", {28'd0, step_idx}, 32'd0);
    reset = 1'b0;
    run(2);

    play(32'h0000_0421, 4'd3);
    run(20);
    check("basic_busy_cycles", 32'(n_busy), 32'd18);
    check("basic_done_pulses", 32'(n_done), 32'd1);

    play(32'h0000_0005, 4'd2);
    check("chord_lines", {28'd0, d_out, c_out, b_out, a_out}, 32'h5);
    run(14);
    check("chord_busy_cycles", 32'(n_busy), 32'd12);
    check("chord_done_pulses", 32'(n_done), 32'd1);

    play(32'h0000_000F, 4'd0);
    run(4);
    check("len0_busy_cycles", 32'(n_busy), 32'd0);
    check("len0_done_pulses", 32'(n_done), 32'd0);

    play($urandom(), 4'd15);
    run(50);
    check("clamp_busy_cycles", 32'(n_busy), 32'd48);
    check("clamp_done_pulses", 32'(n_done), 32'd1);

    play(32'h0000_0421, 4'd3);
    run(8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_lines", {28'd0, d_out, c_out, b_out, a_out}, 32'd0);
    n_done = 0;
    run(8);
    check("abort_no_done", 32'(n_done), 32'd0);
    play(32'h0000_0421, 4'd3);
    check("replay_idx", {28'd0, step_idx}, 32'd0);
    check("replay_a", {31'd0, a_out}, 32'd1);
    run(20);

    play(32'h0000_0021, 4'd2);
    run(4);
    reset = 1'b1;
    tick();
    check("rst_gap_busy", {31'd0, busy}, 32'd0);
    check("rst_gap_idx", {28'd0, step_idx}, 32'd0);
    reset = 1'b0;
    n_busy = 0; n_done = 0;
    run(10);
    check("rst_gap_quiet", 32'(n_busy + n_done), 32'd0);

    play(32'h0000_8421, 4'd4);
    run(3);
    start = 1'b1; seq_data = '1; seq_len = 4'd1;
    tick();
    start = 1'b0;
    run(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(12);
    check("stable_busy_cycles", 32'(n_busy), 32'd24);
    check("stable_done_pulses", 32'(n_done), 32'd1);

    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 79) == 0);
      abort    = ($urandom_range(0, 29) == 0);
      start    = ($urandom_range(0, 5) == 0);
      seq_len  = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      seq_data = $urandom();
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/button_sequence_player.md
# button_sequence_player

Transmitter side of the password-detection button interface. Plays a stored sequence of button presses, including chords of several buttons at once, onto four button lines `a_out`–`d_out`. Each press is held, then released for a gap, with lengths chosen so the downstream debounce filters accept every press. Used as an on-chip stimulus and replay source for the detector path: it drives the debounced inputs that the detector's elongation and coincidence logic expects.

## Interface
- `PRESS_CYCLES`, default 1000: cycles each step's buttons are held high; must be ≥1.
- `GAP_CYCLES`, default 500: cycles all buttons are held low after each step; must be ≥1.
- `MAX_STEPS`, default 8: capacity of the sequence, 1..15.
- `clkin` input 1: sole clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request to play; sampled only in IDLE.
- `abort` input 1: stop playback immediately.
- `seq_data` input 4*MAX_STEPS: step k occupies bits [4k+3:4k], with bit order {d,c,b,a}.
- `seq_len` input 4: number of steps to play.
- `a_out`, `b_out`, `c_out`, `d_out` output 1 each: registered button lines.
- `busy` output 1: high from the first PRESS cycle through the last GAP cycle.
- `done` output 1: one-cycle pulse on normal completion.
- `step_idx` output 4: index of the step currently playing.

## Operation
- States:
  - IDLE: all outputs 0.
  - PRESS: each button line equals its bit in the current step mask.
  - GAP: all button lines 0.
  - DONE: one cycle, `done`=1.
- IDLE→PRESS: taken when `start`=1 and `seq_len`≠0.
  - `seq_data` is latched on this edge.
  - `seq_len` is latched, clamped to MAX_STEPS.
  - `step_idx`=0 and the phase counter is loaded with PRESS_CYCLES−1.
  - The inputs may change afterwards with no effect on playback.
- IDLE with `start`=1 and `seq_len`=0: ignored, stays in IDLE, no `done`.
- PRESS→GAP: when the counter reaches 0; the counter is reloaded with GAP_CYCLES−1.
- GAP→PRESS: when the counter reaches 0 and `step_idx` < len−1; `step_idx` increments.
- GAP→DONE: when the counter reaches 0 and `step_idx` = len−1.
- DONE→IDLE: unconditional after one cycle.
- Mask 0000 is a silent step: all lines stay low for PRESS_CYCLES, then the gap follows as normal.
- `start` while busy or in DONE: ignored. No queuing or retrigger.
- `abort`=1 in PRESS or GAP: next state is IDLE, all lines low, `busy` low, and `done` is not pulsed.
  - `abort` has priority over counter expiry on the same edge.
  - `abort` in IDLE or DONE has no effect; DONE still pulses.
- `reset`=1 at any time, including mid-press: on that edge the FSM goes to IDLE, all outputs 0, counter 0, latched sequence cleared.
- Reset has priority over both `abort` and `start`.
- Counter width is $clog2(max(PRESS_CYCLES, GAP_CYCLES)). It is a down counter and never wraps.

## Timing
- Reset values: `a_out`..`d_out` 0, `busy` 0, `done` 0, `step_idx` 0.
- Latency: `start` sampled on edge T → button lines and `busy` high from edge T (visible in cycle T+1).
- Each PRESS lasts exactly PRESS_CYCLES cycles and each GAP exactly GAP_CYCLES cycles; there are no dead cycles between phases.
- Total `busy` time is len×(PRESS_CYCLES+GAP_CYCLES) cycles.
- `done` is high in the cycle immediately after `busy` falls. `start` is next accepted in the cycle after `done`.
- All outputs are registered: no combinational path from any input to any output.

## Structure
- Shared header `pw_defs`, common to the detector path, holds:
  - the FSM state encodings (2 bits);
  - the button bit indices A=0, B=1, C=2, D=3;
  - default press and gap timing constants, derived from the debounce filter's settle time.
- One sub-module, `phase_timer`: a loadable down counter with a `load`/`value` input and an `expired` output. It is instantiated once, and the FSM and sequence registers live in the top level.

## Test plan
Bench uses PRESS_CYCLES=4, GAP_CYCLES=2, MAX_STEPS=8.
- Basic sequence: `seq_len`=3, masks {0001, 0010, 0100}, `start` pulse.
  - `a_out` high 4 cycles, low 2, then `b_out` likewise, then `c_out`.
  - `busy` high 18 cycles, `done` one cycle at cycle 19, `step_idx` 0→1→2.
- Chord and silent steps: `seq_len`=2, masks {0101, 0000}.
  - `a_out` and `c_out` high together for 4 cycles.
  - The second step has all lines low for 6 cycles.
  - `done` after 12 busy cycles.
- Rejected and clamped requests:
  - `start` with `seq_len`=0 → no `busy`, no `done`.
  - `start` with `seq_len`=15 → plays 8 steps, `busy`=48 cycles.
- Abort mid-press: abort in cycle 3 of step 1 → next cycle all lines 0, `busy` 0, no `done`. A new `start` then replays from step 0.
- Reset mid-gap: reset asserted during GAP of step 0 → all outputs 0 on that edge, `step_idx`=0. A `start` held high through the press is not restarted.
- Ignored start and input stability: `start` repulsed while busy, and `seq_data` changed mid-sequence → playback uses the originally latched masks, exactly one `done`.
